// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: zero-latency lookup, registered update, round-robin victims.
// Optional same-cycle update-to-lookup forwarding is enabled by defining BTB_FWD_EN.
module btb_assoc #(
    parameter int unsigned PC_W     = 32,
    parameter int unsigned SETS     = 8,
    parameter int unsigned WAYS     = 2,
    parameter logic [1:0]  CNT_INIT = 2'b10
) (
    input  logic            clk_i,
    input  logic            rst,
    input  logic            lk_valid,
    input  logic [PC_W-1:0] lk_pc,
    output logic            lk_hit,
    output logic            lk_taken,
    output logic [PC_W-1:0] lk_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            flush
);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned RR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [WAYS-1:0] valid_q  [SETS];
    logic [PC_W-1:0] tag_q    [SETS][WAYS];
    logic [PC_W-1:0] target_q [SETS][WAYS];
    logic [1:0]      cnt_q    [SETS][WAYS];
    logic [RR_W-1:0] rr_q     [SETS];

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] upd_idx;
    assign lk_idx  = lk_pc[IDX_W+1:2];
    assign upd_idx = upd_pc[IDX_W+1:2];

    logic            rd_hit;
    logic [PC_W-1:0] rd_target;
    logic [1:0]      rd_cnt;

    // Lowest-numbered matching way wins.
    always_comb begin
        rd_hit    = 1'b0;
        rd_target = '0;
        rd_cnt    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!rd_hit && valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_pc) begin
                rd_hit    = 1'b1;
                rd_target = target_q[lk_idx][w];
                rd_cnt    = cnt_q[lk_idx][w];
            end
        end
    end

    logic            u_hit;
    logic [RR_W-1:0] u_way;
    logic            inv_found;
    logic [RR_W-1:0] inv_way;
    logic [RR_W-1:0] alloc_way;
    logic [RR_W-1:0] rr_next;
    logic [1:0]      u_cnt;
    logic [1:0]      new_cnt;

    always_comb begin
        u_hit     = 1'b0;
        u_way     = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!u_hit && valid_q[upd_idx][w] && tag_q[upd_idx][w] == upd_pc) begin
                u_hit = 1'b1;
                u_way = RR_W'(w);
            end
            if (!inv_found && !valid_q[upd_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = RR_W'(w);
            end
        end
        alloc_way = inv_found ? inv_way : rr_q[upd_idx];
        rr_next   = (WAYS == 1) ? '0 : rr_q[upd_idx] + 1'b1;
        u_cnt     = cnt_q[upd_idx][u_way];
        if (upd_taken) begin
            new_cnt = (u_cnt == 2'b11) ? 2'b11 : u_cnt + 2'b01;
        end else begin
            new_cnt = (u_cnt == 2'b00) ? 2'b00 : u_cnt - 2'b01;
        end
    end

    // Only valid and rr are cleared; tag/target/cnt contents are don't-care until reallocated.
    always_ff @(posedge clk_i) begin
        if (rst || flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (upd_valid) begin
            if (u_hit) begin
                cnt_q[upd_idx][u_way] <= new_cnt;
                if (upd_taken) begin
                    target_q[upd_idx][u_way] <= upd_target;
                end
            end else if (upd_taken) begin
                valid_q[upd_idx][alloc_way]  <= 1'b1;
                tag_q[upd_idx][alloc_way]    <= upd_pc;
                target_q[upd_idx][alloc_way] <= upd_target;
                cnt_q[upd_idx][alloc_way]    <= CNT_INIT;
                if (!inv_found) begin
                    rr_q[upd_idx] <= rr_next;
                end
            end
        end
    end

    logic            sel_hit;
    logic [PC_W-1:0] sel_target;
    logic [1:0]      sel_cnt;

    always_comb begin
        sel_hit    = rd_hit;
        sel_target = rd_target;
        sel_cnt    = rd_cnt;
`ifdef BTB_FWD_EN
        if (lk_valid && upd_valid && !flush && lk_pc == upd_pc) begin
            sel_hit    = u_hit || upd_taken;
            sel_target = upd_taken ? upd_target : rd_target;
            sel_cnt    = u_hit ? new_cnt : CNT_INIT;
        end
`endif
    end

    assign lk_hit    = lk_valid & sel_hit;
    assign lk_target = lk_hit ? sel_target : '0;
    assign lk_taken  = lk_hit & sel_cnt[1];

endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Parametrised set-associative branch target buffer for the fetch stage.
- Fetch presents a PC and gets, in the same cycle, a hit, a predicted target and a taken/not-taken direction. Direction comes from a per-entry 2-bit saturating counter.
- Execute stage writes resolved branches back through a separate update port.
- Per-set round-robin victim selection; a flush port invalidates all entries on fence/context change.

Parameters:
- PC_W, 32, PC and target width.
- SETS, 8, number of sets (power of two, ≥2); IDX_W = log2(SETS).
- WAYS, 2, ways per set (power of two, 1..8).
- CNT_INIT, 2'b10, counter value written on allocation (weakly taken).

Ports:
- clk_i  in  1  clock.
- rst  in  1  synchronous active-high reset.
- lk_valid  in  1  lookup request from fetch.
- lk_pc  in  PC_W  fetch PC to look up.
- lk_hit  out  1  valid entry with matching tag found.
- lk_taken  out  1  hit and counter MSB = 1.
- lk_target  out  PC_W  stored target on hit, else 0.
- upd_valid  in  1  resolved branch update from execute.
- upd_pc  in  PC_W  branch instruction PC.
- upd_taken  in  1  actual branch outcome.
- upd_target  in  PC_W  actual target (meaningful when upd_taken).
- flush  in  1  invalidate all entries.

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk_i.
- Index = pc[IDX_W+1:2]; tag = full pc (PC_W bits). Word-aligned PCs; pc[1:0] are ignored for indexing but included in the tag compare.
- Per entry: valid, tag, target, cnt[1:0]. Per set: rr pointer, log2(WAYS) bits; 1 bit when WAYS=1, held at 0.
- Lookup is purely combinational, zero latency:
  - lk_hit = lk_valid & any way with valid & tag==lk_pc.
  - lk_target = hit way's target, else 0.
  - lk_taken = lk_hit & cnt[1].
  - All lookup outputs are 0 when lk_valid=0.
  - Multiple matching ways cannot occur by construction; if they do, the lowest-numbered way wins.
- Update, registered on posedge clk_i when upd_valid=1 and flush=0 and rst=0:
  - Hit in set: cnt increments if upd_taken, else decrements, saturating at 3 and 0. If upd_taken, target <= upd_target. rr pointer unchanged.
  - Miss and upd_taken=1: allocate. Target way is the lowest-numbered invalid way; if all ways are valid, the way at rr[set], after which rr[set] <= (rr+1) mod WAYS. Write valid=1, tag=upd_pc, target=upd_target, cnt=CNT_INIT.
  - Miss and upd_taken=0: no state change (not-taken branches are never allocated).
- Flush: on the edge with flush=1, every valid <= 0 and every rr <= 0. Flush has priority over a same-cycle update, which is dropped. Tag, target and cnt are not cleared.
- Reset: same effect as flush. Tag, target and cnt arrays are not reset. Outputs are 0 on the cycle after a reset edge because no entry is valid.
- Reset or flush asserted mid-stream: a lookup in the same cycle still sees pre-edge state (combinational); all lookups from the next cycle miss.
- Same-cycle lookup and update to the same PC: lookup returns pre-update state. The optional feature changes this.
- Counter arithmetic: 2-bit, no wrap.

Optional Feature:
- Macro BTB_FWD_EN.
- Defined: when lk_valid & upd_valid & lk_pc==upd_pc & ~flush, lookup outputs reflect the post-update entry in the same cycle:
  - lk_hit = 1 if the update hits or allocates.
  - lk_target = upd_target if upd_taken, else the stored target.
  - lk_taken = MSB of the new counter.
  - A miss with upd_taken=0 still gives lk_hit=0.
- Undefined: no forwarding; lookup always sees registered state. This saves the PC comparator and muxes on the fetch path.

Test Plan:
1. Reset, then lookup 0x0000_1000 → lk_hit=0, lk_target=0. Update pc=0x1000 taken target=0x2000, next cycle lookup → lk_hit=1, lk_taken=1, lk_target=0x2000.
2. Counter saturation: after allocation at 0x1000, three not-taken updates → cnt 2→1→0→0, lk_taken=0, lk_hit=1. Four taken updates → cnt 3, lk_taken=1.
3. Replacement, SETS=8, WAYS=2: allocate taken branches 0x1000, 0x1020, 0x1040 (all set 0). Third allocation evicts way 0 (0x1000 misses) and rr[0]=1. A fourth, 0x1060, evicts 0x1020.
4. Not-taken miss: update pc=0x3000 not taken → next lookup 0x3000 lk_hit=0; no set state changes.
5. Flush and update in the same cycle (update pc=0x4000 taken) → next cycle 0x4000 and all previously valid PCs miss. Reset asserted during a lookup stream behaves identically.
6. Same-cycle lookup and update of 0x1000 (entry cnt=1, update taken, target 0x5000): with BTB_FWD_EN → lk_taken=1, lk_target=0x5000. Without → lk_taken=0, old target; next cycle both builds show 0x5000, taken.
